// File: rtl/decimating_sample_fifo.sv
// Boxcar decimator for the post-FIR audio path.
// Averages DECIM captured samples and queues the result in a FWFT circular FIFO.
module decimating_sample_fifo #(
  parameter int DECIM = 4,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     ready_in,
  input  logic signed [15:0]       signal_in,
  input  logic                     rd_ready_in,
  output logic                     rd_valid_out,
  output logic signed [15:0]       rd_data_out,
  output logic [$clog2(DEPTH):0]   count_out,
  output logic                     overflow_out
);

  localparam int LD   = $clog2(DECIM);
  localparam int PW   = (LD > 0) ? LD : 1;
  localparam int AW   = 16 + LD;
  localparam int PTRW = $clog2(DEPTH);
  localparam int CW   = PTRW + 1;

  logic                  r_cap;
  logic [PW-1:0]         r_phase;
  logic signed [AW-1:0]  r_acc;
  logic [PTRW-1:0]       r_wr_ptr;
  logic [PTRW-1:0]       r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;
  logic [15:0]           r_mem [DEPTH];

  logic signed [AW-1:0]  w_ext;
  logic signed [AW-1:0]  w_sum;
  logic signed [15:0]    w_result;
  logic                  w_last;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_wr_en;

  assign w_ext    = AW'(signal_in);
  assign w_sum    = r_acc + w_ext;
  assign w_result = 16'(w_sum >>> LD);
  assign w_last   = (r_phase == PW'(DECIM - 1));
  assign w_push   = r_cap && w_last;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_pop    = (r_count != '0) && rd_ready_in;
  // A full FIFO still takes the push when a slot frees this cycle.
  assign w_wr_en  = w_push && (!w_full || w_pop);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cap   <= 1'b0;
      r_phase <= '0;
      r_acc   <= '0;
    end else begin
      r_cap <= ready_in;
      if (r_cap) begin
        if (w_last) begin
          r_phase <= '0;
          r_acc   <= '0;
        end else begin
          r_phase <= r_phase + 1'b1;
          r_acc   <= w_sum;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && w_wr_en) begin
      r_mem[r_wr_ptr] <= w_result;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr_en) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign rd_valid_out = (r_count != '0);
  assign rd_data_out  = r_mem[r_rd_ptr];
  assign count_out    = r_count;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_decimating_sample_fifo.sv
// Scoreboard bench for decimating_sample_fifo.
// Expected averages are queued as stimulus is driven and popped on each read.
module tb_decimating_sample_fifo;

  localparam int DECIM = 4;
  localparam int DEPTH = 16;
  localparam int LD    = $clog2(DECIM);

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               ready_in;
  logic signed [15:0] signal_in;
  logic               rd_ready_in;
  logic               rd_valid_out;
  logic signed [15:0] rd_data_out;
  logic [4:0]         count_out;
  logic               overflow_out;

  int n_chk = 0;
  int n_err = 0;
  int q[$];
  int m_acc = 0;
  int m_ph = 0;
  bit exp_ovf = 0;
  bit lim_en = 0;
  int max_cnt = 0;
  int n_pop = 0;

  always #5 clk_in = ~clk_in;

  decimating_sample_fifo #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .ready_in     (ready_in),
    .signal_in    (signal_in),
    .rd_ready_in  (rd_ready_in),
    .rd_valid_out (rd_valid_out),
    .rd_data_out  (rd_data_out),
    .count_out    (count_out),
    .overflow_out (overflow_out)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic model(input int v);
    int r;
    m_acc += v;
    m_ph++;
    if (m_ph == DECIM) begin
      r = m_acc >>> LD;
      m_acc = 0;
      m_ph = 0;
      if (q.size() < DEPTH || (rd_ready_in && q.size() > 0)) q.push_back(r);
      else exp_ovf = 1;
    end
  endtask

  task automatic do_reset();
    rst_in = 1;
    ready_in = 0;
    rd_ready_in = 0;
    tick();
    tick();
    rst_in = 0;
    q.delete();
    m_acc = 0;
    m_ph = 0;
    exp_ovf = 0;
  endtask

  task automatic send(input int v, input int gap, input bit pop_emit);
    bit keep;
    ready_in = 1;
    tick();
    ready_in = 0;
    signal_in = 16'(v);
    keep = rd_ready_in;
    if (pop_emit) rd_ready_in = 1;
    model(v);
    tick();
    rd_ready_in = keep;
    signal_in = 16'h7abc;
    repeat (gap) tick();
  endtask

  task automatic burst4(input int a, input int b, input int c, input int d);
    ready_in = 1;
    tick();
    signal_in = 16'(a);
    model(a);
    tick();
    signal_in = 16'(b);
    model(b);
    tick();
    signal_in = 16'(c);
    model(c);
    tick();
    ready_in = 0;
    signal_in = 16'(d);
    model(d);
    tick();
    signal_in = 16'h7abc;
  endtask

  task automatic drain_all();
    rd_ready_in = 1;
    for (int i = 0; i < 200 && q.size() > 0; i++) tick();
    check("drain_left", q.size(), 0);
    rd_ready_in = 0;
    tick();
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && rd_valid_out && rd_ready_in) begin
      n_pop++;
      if (q.size() == 0) check("pop_unexp", 1, 0);
      else check("pop_data", int'(rd_data_out), q.pop_front());
    end
    if (lim_en && int'(count_out) > max_cnt) max_cnt = int'(count_out);
  end

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int p0;
    rst_in = 1;
    ready_in = 0;
    rd_ready_in = 0;
    signal_in = 0;
    tick();
    @(negedge clk_in);
    check("rst_valid", int'(rd_valid_out), 0);
    check("rst_count", int'(count_out), 0);
    check("rst_ovf", int'(overflow_out), 0);
    do_reset();

    send(100, 38, 0);
    send(200, 38, 0);
    send(300, 38, 0);
    send(400, 38, 0);
    send(-4, 38, 0);
    send(-4, 38, 0);
    send(-4, 38, 0);
    send(-5, 38, 0);
    @(negedge clk_in);
    check("t1_count", int'(count_out), 2);
    check("t1_head", int'(rd_data_out), 250);
    rd_ready_in = 1;
    tick();
    rd_ready_in = 0;
    @(negedge clk_in);
    check("t1_head2", int'(rd_data_out), -5);
    check("t1_count2", int'(count_out), 1);
    drain_all();

    burst4(1000, -1000, 7, -9);
    @(negedge clk_in);
    check("burst_head", int'(rd_data_out), -1);
    drain_all();

    send(10, 3, 0);
    send(20, 3, 0);
    send(30, 3, 0);
    ready_in = 1;
    @(negedge clk_in);
    check("lat_t0", int'(rd_valid_out), 0);
    tick();
    ready_in = 0;
    signal_in = 16'sd40;
    model(40);
    @(negedge clk_in);
    check("lat_t1", int'(rd_valid_out), 0);
    tick();
    signal_in = 16'h7abc;
    @(negedge clk_in);
    check("lat_t2", int'(rd_valid_out), 1);
    check("lat_cnt", int'(count_out), 1);
    check("lat_head", int'(rd_data_out), 25);
    drain_all();

    do_reset();
    for (int g = 0; g < 17; g++)
      for (int k = 0; k < DECIM; k++)
        send(int'($urandom_range(0, 65535)) - 32768, 0, 0);
    @(negedge clk_in);
    check("full_count", int'(count_out), 16);
    check("full_ovf", int'(overflow_out), int'(exp_ovf));
    check("full_q", q.size(), 16);
    drain_all();
    @(negedge clk_in);
    check("full_empty", int'(count_out), 0);
    check("ovf_sticky", int'(overflow_out), 1);

    do_reset();
    @(negedge clk_in);
    check("ovf_clr", int'(overflow_out), 0);
    for (int g = 0; g < 16; g++)
      for (int k = 0; k < DECIM; k++)
        send(g * 1000 - 8000 + k * 3, 0, 0);
    send(-3000, 0, 0);
    send(-3001, 0, 0);
    send(-3002, 0, 0);
    send(-3003, 0, 1);
    @(negedge clk_in);
    check("sim_count", int'(count_out), 16);
    check("sim_ovf", int'(overflow_out), 0);
    check("sim_q", q.size(), 16);
    drain_all();

    do_reset();
    send(100, 2, 0);
    send(100, 2, 0);
    do_reset();
    send(8, 2, 0);
    send(8, 2, 0);
    send(8, 2, 0);
    send(8, 2, 0);
    @(negedge clk_in);
    check("mid_count", int'(count_out), 1);
    check("mid_head", int'(rd_data_out), 8);
    drain_all();

    do_reset();
    lim_en = 1;
    max_cnt = 0;
    p0 = n_pop;
    rd_ready_in = 1;
    for (int i = 0; i < 20; i++)
      for (int k = 0; k < DECIM; k++)
        send(i * 300 - 3000 + k * 7, 1, 0);
    drain_all();
    lim_en = 0;
    check("wrap_max", max_cnt, 1);
    check("wrap_pops", n_pop - p0, 20);
    @(negedge clk_in);
    check("wrap_empty", int'(count_out), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
